// File: rtl/fetch.sv
// ============================================================================
// Module   : fetch
// Brief    : Qu instruction fetch stage: PC, in-order imem requests, credit-
//            limited instruction queue feeding decode, redirect flush/drop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch #(
    parameter int          INSTR_WIDTH = 32,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_instr,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [31:0]            pc_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 2;

    logic [31:0]            r_fetch_pc;
    logic [c_CNT_W-1:0]     r_inflight;
    logic [c_CNT_W-1:0]     r_drop_cnt;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [INSTR_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
    logic [31:0]            r_q_pc    [QUEUE_DEPTH];
    logic [31:0]            r_pf_pc   [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]     r_pf_rd;
    logic [c_PTR_W-1:0]     r_pf_wr;

    logic [c_SUM_W-1:0]     w_credit_sum;
    logic [c_SUM_W-1:0]     w_drop_total;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_rsp_drop;
    logic                   w_rsp_take;
    logic                   w_out_valid;
    logic                   w_pop;
    logic [c_CNT_W-1:0]     w_inflight_nxt;
    logic [c_CNT_W-1:0]     w_drop_nxt;
    logic [c_CNT_W-1:0]     w_count_nxt;
    logic                   w_unused_redirect_lsb;

    // Every slot already promised to an outstanding or to-be-dropped response
    // counts against the queue, so a returning word always has room.
    assign w_credit_sum = c_SUM_W'(r_count) + c_SUM_W'(r_inflight) + c_SUM_W'(r_drop_cnt);
    assign w_req_valid  = !rst && !redirect_valid && (w_credit_sum < c_SUM_W'(QUEUE_DEPTH));
    assign w_req_fire   = w_req_valid && imem_req_ready;

    assign w_rsp_drop   = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_take   = imem_rsp_valid && (r_drop_cnt == '0) && (r_inflight != '0)
                          && !redirect_valid;

    assign w_out_valid  = (r_count != '0) && !redirect_valid;
    assign w_pop        = w_out_valid && out_ready;

    assign w_drop_total = c_SUM_W'(r_drop_cnt) + c_SUM_W'(r_inflight);
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        w_inflight_nxt = r_inflight;
        w_drop_nxt     = r_drop_cnt;
        w_count_nxt    = r_count;
        if (redirect_valid) begin
            w_inflight_nxt = '0;
            w_count_nxt    = '0;
            // A response landing in the redirect cycle is one of the doomed ones.
            if (imem_rsp_valid && (w_drop_total != '0)) begin
                w_drop_nxt = c_CNT_W'(w_drop_total - c_SUM_W'(1));
            end else begin
                w_drop_nxt = c_CNT_W'(w_drop_total);
            end
        end else begin
            w_drop_nxt     = r_drop_cnt - c_CNT_W'(w_rsp_drop);
            w_inflight_nxt = r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp_take);
            w_count_nxt    = r_count + c_CNT_W'(w_rsp_take) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_pf_rd    <= '0;
            r_pf_wr    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_pf_pc[i]   <= '0;
            end
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;
            r_count    <= w_count_nxt;
            if (redirect_valid) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_pf_rd    <= '0;
                r_pf_wr    <= '0;
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (w_req_fire) begin
                    r_pf_pc[r_pf_wr] <= r_fetch_pc;
                    r_pf_wr          <= r_pf_wr + c_PTR_W'(1);
                    r_fetch_pc       <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_take) begin
                    r_q_instr[r_tail] <= imem_rsp_instr;
                    r_q_pc[r_tail]    <= r_pf_pc[r_pf_rd];
                    r_tail            <= r_tail + c_PTR_W'(1);
                    r_pf_rd           <= r_pf_rd + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_W'(1);
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_out_valid;
    assign instr_out      = r_q_instr[r_head];
    assign pc_out         = r_q_pc[r_head];

    a_push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp_take && (r_count == c_CNT_W'(QUEUE_DEPTH))));

endmodule

`default_nettype wire
